rx_commit_fifo: RTL

Parametrised receive-side payload buffer that sits between the demapper and the UART TX transmitter. Demapped payload bytes are written speculatively. Each frame is committed to the read side, or rolled back, when the demapper reports that frame's CRC result. This replaces resetting the TX FIFO on CRC error and keeps earlier committed frames intact. The block also generates the 16x-baud clock enable and the UART TX enable gate.

---
 rtl/rx_commit_fifo_if.sv | 12 +
 rtl/rx_commit_fifo.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/rx_commit_fifo_if.sv
// Valid/ready word stream used on both the write (demapper) and read (UART TX) sides of
// rx_commit_fifo.
interface rx_commit_fifo_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/rx_commit_fifo.sv
// Receive payload buffer with per-frame commit/rollback on CRC result, plus baud tick and TX gate.
// Optional frame statistics counters are enabled by defining RX_COMMIT_STATS_EN.
module rx_commit_fifo #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned FRAME_LEN = 16,
  parameter int unsigned BAUD_DIV  = 55
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  rx_commit_fifo_if.slave      s,
  rx_commit_fifo_if.master     m,
  input  logic                 i_crc_err,
  input  logic                 i_crc_err_valid,
  input  logic                 i_arq_en,
  input  logic                 i_arq_en_valid,
  output logic                 o_crc_err,
  output logic                 o_tx_enable,
  output logic                 o_frame_drop,
  output logic                 o_sclk_en_16_x_baud,
  output logic [15:0]          o_frames_ok,
  output logic [15:0]          o_frames_dropped
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(FRAME_LEN + 1);
  localparam int unsigned BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  localparam logic [PW:0]   LP_DEPTH     = (PW + 1)'(DEPTH);
  localparam logic [PW:0]   LP_FRAME_FREE = (PW + 1)'(FRAME_LEN);
  localparam logic [CW-1:0] LP_FRAME_LEN = CW'(FRAME_LEN);
  localparam logic [BW-1:0] LP_BAUD_LAST = BW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {StIdle, StFill, StWait} state_e;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_rd_ptr;
  logic [PW-1:0]     r_wr_cmt;
  logic [PW-1:0]     r_wr_spec;
  logic [CW-1:0]     r_cnt;
  state_e            r_state;
  logic              r_arq_en;
  logic              r_crc_err;
  logic              r_frame_drop;
  logic [BW-1:0]     r_baud_cnt;

  logic [PW-1:0]     w_used;
  logic [PW:0]       w_free;
  logic              w_s_ready;
  logic              w_wr_fire;
  logic              w_rd_fire;
  logic              w_m_valid;
  logic              w_drop;
  logic [PW-1:0]     w_spec_nxt;
  logic [CW-1:0]     w_cnt_inc;

  // Pointers carry one extra wrap bit, so the difference is the true occupancy.
  assign w_used = r_wr_spec - r_rd_ptr;
  assign w_free = LP_DEPTH - {1'b0, w_used};

  always_comb begin
    w_s_ready = 1'b0;
    if (!i_rst) begin
      unique case (r_state)
        StIdle:  w_s_ready = (w_free >= LP_FRAME_FREE);
        StFill:  w_s_ready = (r_cnt < LP_FRAME_LEN);
        default: w_s_ready = 1'b0;
      endcase
    end
  end

  assign w_m_valid  = !i_rst && (r_rd_ptr != r_wr_cmt);
  assign w_wr_fire  = s.valid && w_s_ready;
  assign w_rd_fire  = w_m_valid && m.ready;
  assign w_drop     = i_crc_err_valid && r_arq_en && i_crc_err;
  assign w_spec_nxt = r_wr_spec + PW'(w_wr_fire);
  assign w_cnt_inc  = r_cnt + CW'(1);

  assign s.ready = w_s_ready;
  assign m.valid = w_m_valid;
  assign m.data  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (w_wr_fire) begin
      r_mem[r_wr_spec[AW-1:0]] <= s.data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_ptr     <= '0;
      r_wr_cmt     <= '0;
      r_wr_spec    <= '0;
      r_cnt        <= '0;
      r_state      <= StIdle;
      r_arq_en     <= 1'b1;
      r_crc_err    <= 1'b1;
      r_frame_drop <= 1'b0;
    end else begin
      r_frame_drop <= 1'b0;
      if (w_rd_fire) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (i_crc_err_valid) begin
        // A word accepted in the closing cycle belongs to the closing frame.
        r_state <= StIdle;
        r_cnt   <= '0;
        if (w_drop) begin
          r_wr_spec    <= r_wr_cmt;
          r_frame_drop <= 1'b1;
        end else begin
          r_wr_spec <= w_spec_nxt;
          r_wr_cmt  <= w_spec_nxt;
        end
      end else begin
        r_wr_spec <= w_spec_nxt;
        if (!r_arq_en) begin
          r_wr_cmt <= w_spec_nxt;
        end
        if (w_wr_fire) begin
          r_cnt   <= w_cnt_inc;
          r_state <= (w_cnt_inc == LP_FRAME_LEN) ? StWait : StFill;
        end
      end
      if (i_arq_en_valid) begin
        r_arq_en <= i_arq_en;
      end
      if (i_crc_err_valid) begin
        r_crc_err <= i_crc_err;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_baud_cnt <= '0;
    end else if (r_baud_cnt == LP_BAUD_LAST) begin
      r_baud_cnt <= '0;
    end else begin
      r_baud_cnt <= r_baud_cnt + BW'(1);
    end
  end

  assign o_crc_err           = r_crc_err;
  assign o_tx_enable         = !r_arq_en || !r_crc_err;
  assign o_frame_drop        = r_frame_drop;
  assign o_sclk_en_16_x_baud = (r_baud_cnt == LP_BAUD_LAST);

`ifdef RX_COMMIT_STATS_EN
  logic [15:0] r_frames_ok;
  logic [15:0] r_frames_dropped;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_frames_ok      <= '0;
      r_frames_dropped <= '0;
    end else if (i_crc_err_valid) begin
      if (w_drop) begin
        if (r_frames_dropped != 16'hFFFF) r_frames_dropped <= r_frames_dropped + 16'd1;
      end else begin
        if (r_frames_ok != 16'hFFFF) r_frames_ok <= r_frames_ok + 16'd1;
      end
    end
  end

  assign o_frames_ok      = r_frames_ok;
  assign o_frames_dropped = r_frames_dropped;
`else
  assign o_frames_ok      = '0;
  assign o_frames_dropped = '0;
`endif

endmodule
